// File: rtl/probe_capture_pkg.sv
// Shared definitions for the probe capture block: FSM state encoding and
// the default parameter values used by the top level.
package probe_capture_pkg;

  // Capture sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    READ = 3'd4
  } probe_state_t;

  // Default configuration: eight 4-bit channels, 16-sample window,
  // four samples of history ahead of the trigger.
  localparam int DEF_NUM_CH   = 8;
  localparam int DEF_DATA_W   = 4;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_PRE_TRIG = 4;

endpackage

// File: rtl/probe_ram.sv
// Capture buffer: DEPTH x DATA_W, one synchronous write port and one
// synchronous read port. Only the read data register is resettable so the
// popped-sample output starts at zero.
module probe_ram #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store one sample per enabled cycle.
  // NOTE: the array has no reset; its contents are don't-care after reset and
  // leaving it out of the reset lets synthesis map it onto RAM cells.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: registered output, held between pops, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/probe_capture.sv
// Probe capture block: selects one probe channel, records DEPTH consecutive
// samples around a masked-compare trigger (with PRE_TRIG samples of history),
// then lets the stored window be popped oldest-first through a read port.
module probe_capture
  import probe_capture_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PRE_TRIG = DEF_PRE_TRIG
) (
  input  logic                       inClock,
  input  logic                       inReset,
  input  logic [NUM_CH*DATA_W-1:0]   inProbe,
  input  logic [$clog2(NUM_CH)-1:0]  inSel,
  input  logic                       inArm,
  input  logic [DATA_W-1:0]          inTrigMask,
  input  logic [DATA_W-1:0]          inTrigValue,
  input  logic                       inReadEnable,
  output logic [DATA_W-1:0]          outData,
  output logic                       outValid,
  output logic                       outArmed,
  output logic                       outTriggered,
  output logic                       outDone,
  output logic                       outReadError,
  output logic [$clog2(DEPTH):0]     outCount
);

  localparam int SEL_W    = $clog2(NUM_CH);
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int POST_LEN = DEPTH - PRE_TRIG - 1;

  // Last value of the phase counter in PRE and POST respectively.
  localparam logic [AW-1:0] PRE_LAST  = AW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
  localparam logic [AW-1:0] POST_LAST = AW'((POST_LEN > 0) ? POST_LEN - 1 : 0);
  localparam logic [AW-1:0] PRE_OFF   = AW'(PRE_TRIG);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  probe_state_t state, state_next;

  // Configuration latched on arm.
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] value_q;

  // Capture and readout bookkeeping.
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     phase_cnt;
  logic [AW-1:0]     trig_addr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              triggered;
  logic              valid;
  logic              read_error;

  // Decoded per-cycle controls.
  logic [DATA_W-1:0] sample;
  logic              match;
  logic              arm_fire;
  logic              wr_en;
  logic              trig_hit;
  logic              load_read;
  logic              pop;
  logic              bad_read;

  // Channel select mux and trigger compare on the sample being written.
  always_comb begin
    sample = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_q == SEL_W'(c)) begin
        sample = inProbe[c*DATA_W +: DATA_W];
      end
    end
    match = ((sample ^ value_q) & mask_q) == '0;
  end

  // State register.
  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the strobes and status outputs derived from state.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    arm_fire   = 1'b0;
    wr_en      = 1'b0;
    trig_hit   = 1'b0;
    load_read  = 1'b0;
    pop        = 1'b0;
    bad_read   = inReadEnable && (state != READ);
    outArmed   = 1'b0;
    outDone    = 1'b0;

    case (state)
      IDLE: begin
        if (inArm) begin
          arm_fire   = 1'b1;
          state_next = (PRE_TRIG == 0) ? WAIT : PRE;
        end
      end

      PRE: begin
        outArmed = 1'b1;
        wr_en    = 1'b1;
        if (phase_cnt == PRE_LAST) begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        outArmed = 1'b1;
        wr_en    = 1'b1;
        if (match) begin
          trig_hit = 1'b1;
          if (POST_LEN == 0) begin
            load_read  = 1'b1;
            state_next = READ;
          end else begin
            state_next = POST;
          end
        end
      end

      POST: begin
        outArmed = 1'b1;
        wr_en    = 1'b1;
        if (phase_cnt == POST_LAST) begin
          load_read  = 1'b1;
          state_next = READ;
        end
      end

      READ: begin
        outDone = 1'b1;
        if (inReadEnable) begin
          pop = 1'b1;
          if (count == CW'(1)) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: arm latching, write pointer, trigger address, readout pointer
  // and the counters/flags behind the status outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      sel_q      <= '0;
      mask_q     <= '0;
      value_q    <= '0;
      wr_ptr     <= '0;
      phase_cnt  <= '0;
      trig_addr  <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      triggered  <= 1'b0;
      valid      <= 1'b0;
      read_error <= 1'b0;
    end else begin
      valid      <= 1'b0;
      read_error <= bad_read;

      if (arm_fire) begin
        sel_q     <= inSel;
        mask_q    <= inTrigMask;
        value_q   <= inTrigValue;
        wr_ptr    <= '0;
        phase_cnt <= '0;
        count     <= '0;
        triggered <= 1'b0;
      end

      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        // Phase counter restarts whenever the sequencer changes phase.
        if (state_next != state) begin
          phase_cnt <= '0;
        end else begin
          phase_cnt <= phase_cnt + AW'(1);
        end
      end

      if (trig_hit) begin
        trig_addr <= wr_ptr;
        triggered <= 1'b1;
      end

      // Oldest kept sample sits PRE_TRIG slots before the trigger address.
      // On a direct WAIT->READ the trigger address is the current write slot.
      if (load_read) begin
        rd_ptr <= ((state == WAIT) ? wr_ptr : trig_addr) - PRE_OFF;
        count  <= FULL_CNT;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count - CW'(1);
        valid  <= 1'b1;
        if (count == CW'(1)) begin
          triggered <= 1'b0;
        end
      end
    end
  end

  probe_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (inClock),
    .rst     (inReset),
    .we      (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (sample),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (outData)
  );

  assign outValid     = valid;
  assign outTriggered = triggered;
  assign outReadError = read_error;
  assign outCount     = count;

endmodule

// File: doc/probe_capture.md
# probe_capture

Parametrised test-access capture block: selects one of `NUM_CH` probe channels of `DATA_W` bits and records `DEPTH` consecutive samples around a masked-compare trigger into an internal circular buffer. Stored samples are then popped FIFO-style through a read port. It replaces the fixed 8:1 observation muxes of the transceiver test harness. Unlike those muxes, it captures many cycles of history, with a programmable pre-trigger window, instead of a single live value.

## Interface
- `NUM_CH`, 8, number of probe channels (≥2).
- `DATA_W`, 4, bits per channel.
- `DEPTH`, 16, capture buffer depth in samples (power of 2, ≥4).
- `PRE_TRIG`, 4, samples kept before the trigger sample (0 ≤ PRE_TRIG < DEPTH).

Ports:
- `inClock`  in  1  sole clock.
- `inReset`  in  1  asynchronous, active-high reset.
- `inProbe`  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- `inSel`  in  $clog2(NUM_CH)  channel select; latched on arm.
- `inArm`  in  1  start capture (honoured only in IDLE).
- `inTrigMask`  in  DATA_W  compare mask; latched on arm.
- `inTrigValue`  in  DATA_W  compare value; latched on arm.
- `inReadEnable`  in  1  pop one stored sample.
- `outData`  out  DATA_W  popped sample.
- `outValid`  out  1  outData valid, one-cycle pulse.
- `outArmed`  out  1  high in PRE, WAIT, POST.
- `outTriggered`  out  1  high from trigger until return to IDLE.
- `outDone`  out  1  high in READ.
- `outReadError`  out  1  one-cycle pulse on an illegal read.
- `outCount`  out  $clog2(DEPTH)+1  samples remaining to read.

## Operation
- **States:** IDLE, PRE, WAIT, POST, READ.
- **IDLE:**
  - `inArm=1` latches sel, mask and value.
  - Clears the write pointer and counters.
  - Next state is PRE, or WAIT if PRE_TRIG=0.
- **Sampling (PRE, WAIT, POST):** every cycle, the selected channel is written at `wr_ptr`. `wr_ptr` increments modulo DEPTH and wraps freely.
- **PRE:** after PRE_TRIG writes, go to WAIT. The trigger is not evaluated in PRE.
- **WAIT:**
  - Trigger condition: `(sample & mask) == (value & mask)`, evaluated on the sample being written in the same cycle.
  - On a match, that address becomes `trig_addr`, `outTriggered` rises, and the state goes to POST.
  - If POST has zero samples (PRE_TRIG = DEPTH-1), go directly to READ.
  - mask=0 triggers on the first WAIT sample.
- **POST:** write DEPTH-PRE_TRIG-1 further samples, then go to READ.
- **READ entry:**
  - `rd_ptr = (trig_addr - PRE_TRIG) mod DEPTH`.
  - `outCount = DEPTH`.
- **READ, `inReadEnable=1`:**
  - `outData <= mem[rd_ptr]`, `outValid` pulses, `rd_ptr` increments with wrap, `outCount` decrements.
  - The pop that brings outCount to 0 also returns the state to IDLE.
- **Illegal read:** `inReadEnable` in any state other than READ pulses `outReadError`. outData, outValid and outCount are unchanged.
- **Ignored inputs:** `inArm` outside IDLE is ignored. inSel, mask and value changes after the arm cycle are ignored.
- **Reset (asynchronous, any state, including mid-capture):**
  - State goes to IDLE; pointers and counters clear.
  - All outputs go to 0.
  - Buffer contents are don't-care.
- **Width rules:** `outCount` has enough width to hold DEPTH. Pointers are $clog2(DEPTH) bits with natural wrap.

## Timing
- **Arm:** arm sampled at edge k. The first captured sample is the `inProbe` value at edge k+1.
- **Total capture:** exactly DEPTH writes, PRE_TRIG + 1 (trigger) + post, counting only the tail of WAIT.
- **Trigger flag:** `outTriggered` rises the cycle after the trigger edge.
- **READ entry:** `outDone` rises the cycle after the last write.
- **Read latency:** 1 cycle; `inReadEnable` at edge n gives outData/outValid visible after edge n.
- **Back-to-back reads:** reads on consecutive cycles are legal, one sample per cycle.
- **Exit:** `outDone` falls after the final pop. `inArm` is accepted the following cycle.
- **Reset values:** all outputs 0.

## Structure
- **Shared package `probe_capture_pkg`:**
  - State enum `probe_state_t` {IDLE, PRE, WAIT, POST, READ}.
  - Default-parameter constants.
- **Sub-module `probe_ram`:** DEPTH×DATA_W, one synchronous write port, one synchronous read port, no reset on the array.
- **Top level:** the channel select mux, trigger compare and FSM stay in the top.

## Test plan
Bench defaults: NUM_CH=8, DATA_W=4, DEPTH=16, PRE_TRIG=4.
1. **Reset:** assert `inReset` → all outputs 0. Pulse `inReadEnable` → `outReadError` pulses and outCount stays 0.
2. **Basic capture:**
   - Stimulus: sel=3, ch3 driven with a 4-bit ramp starting at 0 on the first capture cycle, mask=F, value=A.
   - Response: 16 reads return 6,7,…,F,0,1,…,5; outCount steps 16→0; the state returns to IDLE.
3. **Immediate trigger:** mask=0 → trigger on capture index 4; readout returns capture indices 0..15 in order.
4. **Read before done:** inReadEnable during WAIT → outReadError pulses one cycle; no outValid; the capture completes normally.
5. **Reset mid-capture:** assert reset mid-POST → outputs reset to 0. A re-arm with sel=0 then captures channel 0 correctly.
6. **Ignored inputs, then overrun:**
   - Arm with sel=1, then change sel to 5 and pulse inArm again during POST → channel 1 data captured, re-arm ignored.
   - After 16 reads, a 17th read pulses outReadError with outDone=0.
